// File: rtl/elgamal_decryptor.sv
// ElGamal decryptor: s = c1^a mod q, s_inv = s^(q-2) mod q, msg = c2*s_inv mod q on one square-and-multiply engine.
// Optional input range rejection enabled by defining ELGAMAL_DEC_RANGE_CHECK_EN.
module elgamal_decryptor #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] c1,
  input  logic [W-1:0] c2,
  input  logic [W-1:0] priv_a,
  input  logic [W-1:0] q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] msg,
  output logic         err
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, EXP_SQ, EXP_MUL, FINAL, DONE} state_t;

  state_t          state;
  logic [W-1:0]    c1_r, c2_r, a_r, q_r;
  logic [W-1:0]    c1m, c2m, s_r, acc;
  logic [IW-1:0]   idx;
  logic            phase;

  logic [W-1:0]    exp_cur, base_cur, sq_val, mul_val, step_val;
  logic            bit_set, do_step;

  // Full 2W-bit product reduced mod m; nothing is truncated before the reduction.
  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] m);
    logic [2*W-1:0] p;
    logic [2*W-1:0] r;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    r = p % {{W{1'b0}}, m};
    return r[W-1:0];
  endfunction

  always_comb begin
    exp_cur  = phase ? (q_r - W'(2)) : a_r;
    base_cur = phase ? s_r : c1m;
    sq_val   = mod_mul(acc, acc, q_r);
    mul_val  = mod_mul(acc, base_cur, q_r);
    bit_set  = exp_cur[idx];
    step_val = (state == EXP_MUL) ? mul_val : sq_val;
    do_step  = (state == EXP_MUL) || ((state == EXP_SQ) && !bit_set);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      msg       <= '0;
      err       <= 1'b0;
      c1_r      <= '0;
      c2_r      <= '0;
      a_r       <= '0;
      q_r       <= '0;
      c1m       <= '0;
      c2m       <= '0;
      s_r       <= '0;
      acc       <= '0;
      idx       <= '0;
      phase     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            c1_r     <= c1;
            c2_r     <= c2;
            a_r      <= priv_a;
            q_r      <= q;
            in_ready <= 1'b0;
            state    <= LOAD;
          end else begin
            in_ready <= 1'b1;
          end
        end
        LOAD: begin
          acc   <= W'(1);
          idx   <= IW'(W - 1);
          phase <= 1'b0;
          err   <= 1'b0;
`ifdef ELGAMAL_DEC_RANGE_CHECK_EN
          if ((q_r < W'(3)) || (c1_r == '0) || (c1_r >= q_r) || (c2_r >= q_r)) begin
            err   <= 1'b1;
            msg   <= '0;
            state <= DONE;
          end else begin
            c1m   <= c1_r;
            c2m   <= c2_r;
            state <= EXP_SQ;
          end
`else
          c1m   <= c1_r % q_r;
          c2m   <= c2_r % q_r;
          state <= EXP_SQ;
`endif
        end
        EXP_SQ, EXP_MUL: begin
          if (!do_step) begin
            acc   <= sq_val;
            state <= EXP_MUL;
          end else if (idx != '0) begin
            acc   <= step_val;
            idx   <= idx - IW'(1);
            state <= EXP_SQ;
          end else if (!phase) begin
            // c1^a is done: it becomes the base for the Fermat inverse.
            s_r   <= step_val;
            acc   <= W'(1);
            idx   <= IW'(W - 1);
            phase <= 1'b1;
            state <= EXP_SQ;
          end else begin
            acc   <= step_val;
            state <= FINAL;
          end
        end
        FINAL: begin
          msg       <= mod_mul(c2m, acc, q_r);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // A rejected op arrives here with out_valid low and raises it one cycle later.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
